// File: rtl/mult_job_sequencer_if.sv
// Bus bundle between a job source/sink, the job sequencer and the shift-and-add multiplier.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface mult_job_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_multiplicand;
    logic [WIDTH-1:0]       in_multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_product;
    logic                   out_error;
    logic                   mul_reset_n;
    logic                   mul_start;
    logic                   mul_ready;
    logic [WIDTH-1:0]       mul_multiplicand;
    logic [WIDTH-1:0]       mul_multiplier;
    logic [2*WIDTH-1:0]     mul_product;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, out_ready, mul_ready, mul_product,
        output in_ready, out_valid, out_product, out_error,
               mul_reset_n, mul_start, mul_multiplicand, mul_multiplier
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, out_ready, mul_ready, mul_product,
        input  in_ready, out_valid, out_product, out_error,
               mul_reset_n, mul_start, mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mult_job_sequencer.sv
// Job front-end for the shift-and-add multiplier: accepts operand pairs, re-arms and starts the
// multiplier per job, captures the product (or a watchdog error) and hands it out over valid/ready.
module mult_job_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 2 * WIDTH + 4
) (
    input  logic                    clock,
    input  logic                    reset,
    mult_job_sequencer_if.slave     bus
);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               mul_reset_n_q, mul_reset_n_d;
    logic               mul_start_q, mul_start_d;

    // Next state, datapath updates and outputs decoded from the next state so they land registered.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        wd_d     = wd_q;
        prod_d   = prod_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.in_multiplicand;
                    mplier_d = bus.in_multiplier;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready on the last watchdog cycle still counts as a good result.
                if (bus.mul_ready) begin
                    prod_d  = bus.mul_product;
                    err_d   = 1'b0;
                    state_d = S_OUTPUT;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d    = (state_d == S_IDLE);
        out_valid_d   = (state_d == S_OUTPUT);
        mul_reset_n_d = (state_d != S_IDLE);
        mul_start_d   = (state_d == S_ARM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mcand_q       <= '0;
            mplier_q      <= '0;
            wd_q          <= '0;
            prod_q        <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            mul_reset_n_q <= 1'b0;
            mul_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            wd_q          <= wd_d;
            prod_q        <= prod_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            mul_reset_n_q <= mul_reset_n_d;
            mul_start_q   <= mul_start_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_product      = prod_q;
    assign bus.out_error        = err_q;
    assign bus.mul_reset_n      = mul_reset_n_q;
    assign bus.mul_start        = mul_start_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_multiplier   = mplier_q;
endmodule
